// File: rtl/of_header_parser.sv
// Flow-key extractor tapping the 64-bit packet stream: collects the IOQ port and
// the L2/L3/L4 fields from the first five data words and emits one packed key per packet.
module of_header_parser #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int                    HEADER_WIDTH = 232,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL     = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    input  logic                    in_wr,
    output logic [HEADER_WIDTH-1:0] header_bus,
    output logic                    headers_valid,
    output logic [31:0]             num_pkts_parsed
);

    typedef enum logic [2:0] {
        ST_MOD_HDRS = 3'd0,
        ST_W1       = 3'd1,
        ST_W2       = 3'd2,
        ST_W3       = 3'd3,
        ST_W4       = 3'd4,
        ST_WAIT_EOP = 3'd5
    } state_t;

    localparam logic [CTRL_WIDTH-1:0] CTRL_DATA = 8'h00;

    state_t                  state_q,     state_d;
    logic                    ioq_seen_q,  ioq_seen_d;
    logic [15:0]             in_port_q,   in_port_d;
    logic [47:0]             dl_dst_q,    dl_dst_d;
    logic [47:0]             dl_src_q,    dl_src_d;
    logic [15:0]             dl_type_q,   dl_type_d;
    logic [7:0]              ver_ihl_q,   ver_ihl_d;
    logic [7:0]              proto_q,     proto_d;
    logic [31:0]             nw_src_q,    nw_src_d;
    logic [31:0]             nw_dst_q,    nw_dst_d;
    logic [15:0]             tp_src_q,    tp_src_d;
    logic [15:0]             tp_dst_q,    tp_dst_d;
    logic [HEADER_WIDTH-1:0] header_bus_q, header_bus_d;
    logic                    headers_valid_q, headers_valid_d;
    logic [31:0]             num_pkts_q,  num_pkts_d;

    logic                    emit_s;
    logic                    is_ip_s;
    logic                    tp_ok_s;
    logic [HEADER_WIDTH-1:0] packed_s;

    // Next-state and field-capture logic for the packet walk.
    always_comb begin
        state_d    = state_q;
        ioq_seen_d = ioq_seen_q;
        in_port_d  = in_port_q;
        dl_dst_d   = dl_dst_q;
        dl_src_d   = dl_src_q;
        dl_type_d  = dl_type_q;
        ver_ihl_d  = ver_ihl_q;
        proto_d    = proto_q;
        nw_src_d   = nw_src_q;
        nw_dst_d   = nw_dst_q;
        tp_src_d   = tp_src_q;
        tp_dst_d   = tp_dst_q;
        emit_s     = 1'b0;
        if (in_wr) begin
            case (state_q)
                ST_MOD_HDRS: begin
                    if (in_ctrl == IOQ_CTRL || in_ctrl == CTRL_DATA) begin
                        dl_dst_d  = 48'h0;
                        dl_src_d  = 48'h0;
                        dl_type_d = 16'h0;
                        ver_ihl_d = 8'h0;
                        proto_d   = 8'h0;
                        nw_src_d  = 32'h0;
                        nw_dst_d  = 32'h0;
                        tp_src_d  = 16'h0;
                        tp_dst_d  = 16'h0;
                    end else begin
                        state_d = ST_MOD_HDRS;
                    end
                    if (in_ctrl == IOQ_CTRL) begin
                        in_port_d  = in_data[31:16];
                        ioq_seen_d = 1'b1;
                    end else if (in_ctrl == CTRL_DATA) begin
                        // A packet arriving without an IOQ word reports port 0.
                        in_port_d       = ioq_seen_q ? in_port_q : 16'h0;
                        ioq_seen_d      = 1'b0;
                        dl_dst_d        = in_data[63:16];
                        dl_src_d[47:32] = in_data[15:0];
                        state_d         = ST_W1;
                    end else begin
                        ioq_seen_d = ioq_seen_q;
                    end
                end
                ST_W1: begin
                    dl_src_d[31:0] = in_data[63:32];
                    dl_type_d      = in_data[31:16];
                    ver_ihl_d      = in_data[15:8];
                    state_d        = ST_W2;
                end
                ST_W2: begin
                    proto_d = in_data[7:0];
                    state_d = ST_W3;
                end
                ST_W3: begin
                    nw_src_d        = in_data[47:16];
                    nw_dst_d[31:16] = in_data[15:0];
                    state_d         = ST_W4;
                end
                ST_W4: begin
                    nw_dst_d[15:0] = in_data[63:48];
                    tp_src_d       = in_data[47:32];
                    tp_dst_d       = in_data[31:16];
                    state_d        = ST_WAIT_EOP;
                    emit_s         = 1'b1;
                end
                ST_WAIT_EOP: begin
                    if (in_ctrl != CTRL_DATA) begin
                        state_d = ST_MOD_HDRS;
                    end else begin
                        state_d = ST_WAIT_EOP;
                    end
                end
                default: begin
                    state_d = ST_MOD_HDRS;
                end
            endcase
            // An EOP inside W1..W4 ends a short packet: emit what was gathered.
            if ((state_q == ST_W1 || state_q == ST_W2 || state_q == ST_W3 || state_q == ST_W4)
                && in_ctrl != CTRL_DATA) begin
                emit_s  = 1'b1;
                state_d = ST_MOD_HDRS;
            end else begin
                emit_s = emit_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Qualify L3/L4 fields and pack the key from the values including the emitting word.
    always_comb begin
        is_ip_s  = (dl_type_d == 16'h0800);
        tp_ok_s  = is_ip_s && (ver_ihl_d == 8'h45) && (proto_d == 8'd6 || proto_d == 8'd17);
        packed_s = {in_port_d, dl_dst_d, dl_src_d, dl_type_d,
                    is_ip_s ? nw_src_d : 32'h0,
                    is_ip_s ? nw_dst_d : 32'h0,
                    is_ip_s ? proto_d  : 8'h0,
                    tp_ok_s ? tp_src_d : 16'h0,
                    tp_ok_s ? tp_dst_d : 16'h0};
        if (emit_s) begin
            header_bus_d = packed_s;
            num_pkts_d   = num_pkts_q + 32'd1;
        end else begin
            header_bus_d = header_bus_q;
            num_pkts_d   = num_pkts_q;
        end
        headers_valid_d = emit_s;
    end

    // State, field and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_MOD_HDRS;
            ioq_seen_q      <= 1'b0;
            in_port_q       <= 16'h0;
            dl_dst_q        <= 48'h0;
            dl_src_q        <= 48'h0;
            dl_type_q       <= 16'h0;
            ver_ihl_q       <= 8'h0;
            proto_q         <= 8'h0;
            nw_src_q        <= 32'h0;
            nw_dst_q        <= 32'h0;
            tp_src_q        <= 16'h0;
            tp_dst_q        <= 16'h0;
            header_bus_q    <= {HEADER_WIDTH{1'b0}};
            headers_valid_q <= 1'b0;
            num_pkts_q      <= 32'h0;
        end else begin
            state_q         <= state_d;
            ioq_seen_q      <= ioq_seen_d;
            in_port_q       <= in_port_d;
            dl_dst_q        <= dl_dst_d;
            dl_src_q        <= dl_src_d;
            dl_type_q       <= dl_type_d;
            ver_ihl_q       <= ver_ihl_d;
            proto_q         <= proto_d;
            nw_src_q        <= nw_src_d;
            nw_dst_q        <= nw_dst_d;
            tp_src_q        <= tp_src_d;
            tp_dst_q        <= tp_dst_d;
            header_bus_q    <= header_bus_d;
            headers_valid_q <= headers_valid_d;
            num_pkts_q      <= num_pkts_d;
        end
    end

    assign header_bus      = header_bus_q;
    assign headers_valid   = headers_valid_q;
    assign num_pkts_parsed = num_pkts_q;

endmodule
